// File: rtl/retire_check_monitor.sv
// retire_check_monitor
//   End-of-program self-check block for the pipelined CPU. It keeps shadow copies of
//   x1..xNUM_CHECK from writeback traffic and counts RUN cycles and retired instructions.
//   A run ends when a branch-to-self halt loop is seen (HALT_REPEAT consecutive retires of one
//   PC) or when the watchdog expires. On halt the shadows are compared against the expected
//   values under a mask, and the block raises pass or fail.
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   wb_en/wb_rd/wb_data    register-file writeback snoop
//   ret_valid/ret_pc       retire snoop
//   exp_mask/exp_vals      expected values; bit i / slice i correspond to x(i+1)
//   chk_regs               shadow registers; slice i is x(i+1)
//   cycle_cnt/retire_cnt   saturating counters of RUN cycles and RUN retires
//   state                  0 IDLE, 1 RUN, 2 CHECK, 3 DONE
//   done/pass/fail/timeout sticky result flags
//   fail_idx               lowest mismatching register number, 0 if none
module retire_check_monitor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NUM_CHECK   = 6,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned TIMEOUT     = 5000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_en,
  input  logic [4:0]                wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic                      ret_valid,
  input  logic [XLEN-1:0]           ret_pc,
  input  logic [NUM_CHECK-1:0]      exp_mask,
  input  logic [NUM_CHECK*XLEN-1:0] exp_vals,
  output logic [NUM_CHECK*XLEN-1:0] chk_regs,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic [1:0]                state,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout,
  output logic [4:0]                fail_idx
);

  localparam int unsigned REP_W  = $clog2(HALT_REPEAT + 1);
  localparam int unsigned SHAD_W = NUM_CHECK * XLEN;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SHAD_W-1:0]  chk_q, chk_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   retire_q, retire_d;
  logic [XLEN-1:0]    last_pc_q, last_pc_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic [4:0]         fail_idx_q, fail_idx_d;

  logic               halt;
  logic               mismatch;
  logic [4:0]         mismatch_idx;

  // Shadow update: frozen once the run is over.
  always_comb begin
    chk_d = chk_q;
    if (state_q != ST_DONE && wb_en) begin
      for (int i = 0; i < int'(NUM_CHECK); i++) begin
        if (wb_rd == 5'(i + 1)) chk_d[i*XLEN +: XLEN] = wb_data;
      end
    end
  end

  // Compare against the next shadow value so a writeback landing in CHECK is included.
  always_comb begin
    mismatch     = 1'b0;
    mismatch_idx = 5'd0;
    for (int i = int'(NUM_CHECK) - 1; i >= 0; i--) begin
      if (exp_mask[i] && (chk_d[i*XLEN +: XLEN] != exp_vals[i*XLEN +: XLEN])) begin
        mismatch     = 1'b1;
        mismatch_idx = 5'(i + 1);
      end
    end
  end

  // Halt-loop tracker: bubbles leave the repeat count untouched.
  always_comb begin
    last_pc_d = last_pc_q;
    rep_d     = rep_q;
    if (ret_valid && (state_q == ST_IDLE || state_q == ST_RUN)) begin
      if (ret_pc == last_pc_q) begin
        if (rep_q != REP_W'(HALT_REPEAT)) rep_d = rep_q + REP_W'(1);
      end else begin
        rep_d     = REP_W'(1);
        last_pc_d = ret_pc;
      end
    end
    halt = (state_q == ST_RUN) && ret_valid && (rep_d == REP_W'(HALT_REPEAT));
  end

  // Next-state, counters and result flags.
  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    retire_d   = retire_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    fail_idx_d = fail_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (ret_valid) begin
          state_d  = ST_RUN;
          cycle_d  = CNT_W'(1);
          retire_d = CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
        if (ret_valid && retire_q != '1) retire_d = retire_q + CNT_W'(1);
        // Halt takes priority over a watchdog expiring in the same cycle.
        if (halt) begin
          state_d = ST_CHECK;
        end else if (cycle_d >= CNT_W'(TIMEOUT)) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          timeout_d  = 1'b1;
          fail_d     = 1'b1;
          pass_d     = 1'b0;
          fail_idx_d = 5'd0;
        end
      end
      ST_CHECK: begin
        state_d    = ST_DONE;
        done_d     = 1'b1;
        pass_d     = !mismatch;
        fail_d     = mismatch;
        fail_idx_d = mismatch_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      chk_q      <= '0;
      cycle_q    <= '0;
      retire_q   <= '0;
      last_pc_q  <= '0;
      rep_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_idx_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      chk_q      <= chk_d;
      cycle_q    <= cycle_d;
      retire_q   <= retire_d;
      last_pc_q  <= last_pc_d;
      rep_q      <= rep_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign chk_regs   = chk_q;
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign state      = state_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign fail_idx   = fail_idx_q;

endmodule
